// File: rtl/mac_accumulator.sv
// Pipelined signed multiply-accumulate stage.
// Operand pairs arrive on a valid/ready input. Their scaled products are summed
// per vector (the vector ends at in_last), and one rescaled, truncated result per
// vector leaves on a valid/ready output. The pipeline is S1 (operands), then
// S2 (product), then the accumulator and output register.
module mac_accumulator #(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 16,
  parameter int PROD_SCALE = 0,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int OUT_SCALE  = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 arst_n_in,
  input  logic                 clear,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // The product is formed wide enough for both the full-precision result and
  // the accumulator, so the sign extension before truncation is exact.
  localparam int PROD_W = A_WIDTH + B_WIDTH;
  localparam int WIDE_W = (ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                        stall;

  logic                        s1_valid;
  logic                        s1_last;
  logic signed [A_WIDTH-1:0]   s1_a;
  logic signed [B_WIDTH-1:0]   s1_b;

  logic                        s2_valid;
  logic                        s2_last;
  logic signed [ACC_WIDTH-1:0] s2_prod;

  logic signed [ACC_WIDTH-1:0] acc;
  logic                        first;
  logic [CNT_WIDTH-1:0]        count;

  logic signed [WIDE_W-1:0]    a_ext;
  logic signed [WIDE_W-1:0]    b_ext;
  logic signed [WIDE_W-1:0]    prod_full;
  logic signed [ACC_WIDTH-1:0] prod_acc;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic [CNT_WIDTH-1:0]        count_inc;

  // A result that is held and not consumed freezes the whole pipeline.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Product, running sum and saturating beat count for the beat in S2.
  // NOTE: each signal is assigned exactly once on every path. That keeps the block purely combinational, so no latch is inferred.
  always_comb begin
    a_ext     = WIDE_W'(s1_a);
    b_ext     = WIDE_W'(s1_b);
    prod_full = a_ext * b_ext;
    prod_acc  = ACC_WIDTH'(prod_full >>> PROD_SCALE);
    acc_base  = first ? '0 : acc;
    acc_next  = acc_base + s2_prod;
    count_inc = (count == CNT_MAX) ? count : count + CNT_WIDTH'(1);
  end

  // S1: capture the operands of an accepted beat. A bubble is captured when no beat is accepted.
  // NOTE: non-blocking assignments let every stage sample its predecessor's value from before the edge.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_last  <= in_last;
      s1_a     <= in_a;
      s1_b     <= in_b;
    end
  end

  // S2: register the scaled product truncated to accumulator width.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_prod  <= '0;
    end else if (clear) begin
      s2_valid <= 1'b0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_prod  <= prod_acc;
    end
  end

  // Accumulator: fold each product into the vector sum and restart after the last beat.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      acc   <= '0;
      first <= 1'b1;
      count <= '0;
    end else if (clear) begin
      first <= 1'b1;
      count <= '0;
    end else if (!stall && s2_valid) begin
      acc <= acc_next;
      if (s2_last) begin
        first <= 1'b1;
        count <= '0;
      end else begin
        first <= 1'b0;
        count <= count_inc;
      end
    end
  end

  // Output register: load a finished vector, or drop valid once the held result is consumed.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (s2_valid && s2_last) begin
        out_valid <= 1'b1;
        out_data  <= OUT_WIDTH'(acc_next >>> OUT_SCALE);
        out_count <= count_inc;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Testbench for mac_accumulator.
// Directed and random operand streams are fed to the design. A transaction-level
// reference model adds up the scaled products of each accepted vector and queues
// the expected rescaled result. Every result handshake is compared with that queue.
module tb_mac_accumulator;

  localparam int A_W   = 16;
  localparam int B_W   = 16;
  localparam int PS    = 0;
  localparam int ACC_W = 32;
  localparam int OUT_W = 16;
  localparam int OS    = 8;
  localparam int CNT_W = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [CNT_W-1:0] c;
  } res_t;

  logic                  clk = 1'b0;
  logic                  arst_n_in;
  logic                  clear;
  logic signed [A_W-1:0] in_a;
  logic signed [B_W-1:0] in_b;
  logic                  in_last;
  logic                  in_valid;
  logic                  in_ready;
  logic [OUT_W-1:0]      out_data;
  logic [CNT_W-1:0]      out_count;
  logic                  out_valid;
  logic                  out_ready;

  int     checks = 0;
  int     errors = 0;
  res_t   exp_q[$];
  longint m_sum  = 0;
  int     m_cnt  = 0;
  logic   prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data;
  logic [CNT_W-1:0] prev_count;

  always #5 clk = ~clk;

  mac_accumulator #(
    .A_WIDTH(A_W), .B_WIDTH(B_W), .PROD_SCALE(PS), .ACC_WIDTH(ACC_W),
    .OUT_WIDTH(OUT_W), .OUT_SCALE(OS), .CNT_WIDTH(CNT_W)
  ) u_dut (
    .clk(clk), .arst_n_in(arst_n_in), .clear(clear),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_res(input string tag, input int d, input int c);
    logic [OUT_W-1:0] ed;
    logic [CNT_W-1:0] ec;
    ed = d[OUT_W-1:0];
    ec = c[CNT_W-1:0];
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_count"}, out_count, ec);
  endtask

  // Reference: a vector's result is its product sum wrapped to ACC_W bits and
  // arithmetically shifted. Only the low OUT_W bits are kept.
  function automatic res_t expect_of(input longint s, input int c);
    res_t r;
    logic signed [ACC_W-1:0] wrapped;
    longint sh;
    wrapped = s[ACC_W-1:0];
    sh      = longint'(wrapped) >>> OS;
    r.d     = sh[OUT_W-1:0];
    r.c     = c[CNT_W-1:0];
    return r;
  endfunction

  task automatic model_beat(input logic signed [A_W-1:0] a, input logic signed [B_W-1:0] b,
                            input logic last);
    longint p;
    p = (longint'(a) * longint'(b)) >>> PS;
    m_sum += p;
    if (m_cnt < CNT_SAT) m_cnt++;
    if (last) begin
      exp_q.push_back(expect_of(m_sum, m_cnt));
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  task automatic model_flush();
    m_sum = 0;
    m_cnt = 0;
    exp_q.delete();
    prev_stall = 1'b0;
  endtask

  // One clock cycle, entered and left at the falling edge with inputs already driven.
  task automatic cycle();
    res_t r;
    #1;
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
      chk("hold_count", out_count, prev_count);
    end
    if (out_valid && out_ready) begin
      chk("result_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk("res_data", out_data, r.d);
        chk("res_count", out_count, r.c);
      end
    end
    if (in_valid && in_ready && !clear) model_beat(in_a, in_b, in_last);
    if (clear) model_flush();
    prev_stall = out_valid && !out_ready && !clear;
    prev_data  = out_data;
    prev_count = out_count;
    @(negedge clk);
  endtask

  task automatic send(input int a, input int b, input logic last);
    int   tries;
    logic took;
    tries    = 0;
    in_valid = 1'b1;
    in_a     = a[A_W-1:0];
    in_b     = b[B_W-1:0];
    in_last  = last;
    do begin
      took = in_ready;
      cycle();
      tries++;
    end while (!took && tries < 100);
    chk("send_accepted", took, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    in_valid = 1'b0;
    while (!out_valid && n < 40) begin
      cycle();
      n++;
    end
    chk({tag, "_arrive"}, out_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      cycle();
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_out_valid", out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    arst_n_in = 1'b0;
    clear     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    prev_data = '0;
    prev_count = '0;

    // Reset state
    #12;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_in_ready", in_ready, 1);
    arst_n_in = 1'b1;
    @(negedge clk);

    // Test 1: reset while a result is held and a partial vector is in flight
    out_ready = 1'b0;
    send(1000, 256, 1'b1);
    send(300, 256, 1'b0);
    send(300, 256, 1'b0);
    wait_out("t1");
    chk("t1_stalled_in_ready", in_ready, 0);
    arst_n_in = 1'b0;
    #1;
    chk("t1_rst_valid", out_valid, 0);
    chk("t1_rst_data", out_data, 0);
    chk("t1_rst_count", out_count, 0);
    model_flush();
    @(negedge clk);
    arst_n_in = 1'b1;
    chk("t1_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("t1_no_stale", out_valid, 0);
      cycle();
    end
    send(256, 3, 1'b1);
    wait_out("t1_fresh");
    chk_res("t1_fresh", 3, 1);
    cycle();

    // Test 2: single-beat latency, one valid cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 16'sd256;
    in_b      = -16'sd4;
    in_last   = 1'b1;
    cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("t2_n1_valid", out_valid, 0);
    cycle();
    chk("t2_n2_valid", out_valid, 0);
    cycle();
    chk("t2_n3_valid", out_valid, 1);
    chk_res("t2", -4, 1);
    cycle();
    chk("t2_n4_valid", out_valid, 0);

    // Test 3: back-to-back vector, then a flooring single beat
    send(100, 256, 1'b0);
    send(200, 256, 1'b0);
    send(-300, 256, 1'b0);
    send(50, 256, 1'b1);
    wait_out("t3a");
    chk_res("t3a", 50, 4);
    cycle();
    send(-1, 1, 1'b1);
    wait_out("t3b");
    chk_res("t3b", -1, 1);
    cycle();

    // Test 4: stalled output, then handshake with a new result arriving the same cycle
    out_ready = 1'b0;
    send(512, 1, 1'b1);
    send(768, 1, 1'b1);
    wait_out("t4");
    for (int i = 0; i < 5; i++) begin
      chk_res("t4_hold", 2, 1);
      chk("t4_in_ready", in_ready, 0);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    chk("t4_valid_kept", out_valid, 1);
    chk_res("t4_next", 3, 1);
    cycle();
    chk("t4_valid_drop", out_valid, 0);

    // Test 5: accumulator wrap
    for (int i = 0; i < 4; i++) send(-32768, -32768, i == 3);
    wait_out("t5");
    chk_res("t5", 0, 4);
    cycle();

    // Test 6: clear drops a partial vector and the beat presented with it
    send(256, 100, 1'b0);
    send(256, 100, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_a     = 16'sd5;
    in_b     = 16'sd5;
    in_last  = 1'b1;
    cycle();
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    send(256, 1, 1'b1);
    wait_out("t6");
    chk_res("t6", 1, 1);
    cycle();
    idle(4);

    // Test 7: beat count saturation
    for (int i = 0; i < 260; i++) send(1, 1, i == 259);
    wait_out("t7");
    chk_res("t7", 1, CNT_SAT);
    cycle();

    // Test 8: random operands, random gaps and back-pressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_a      = A_W'($urandom);
      in_b      = B_W'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    out_ready = 1'b1;
    send(7, 9, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
